// File: rtl/cmd_frame_rcv_pkg.sv
// Shared definitions for the three-byte command link: FSM encodings and
// the field layout of the assembled command word.
package cmd_frame_rcv_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, MID = 2'd1, LOW = 2'd2} rx_state_e;
  typedef enum logic {TIDLE = 1'b0, TBUSY = 1'b1} tx_state_e;

  localparam int FRAME_BYTES = 3;
  localparam int CMD_W       = 8 * FRAME_BYTES;

  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 16;
  localparam int DHI_MSB = 15;
  localparam int DHI_LSB = 8;
  localparam int DLO_MSB = 7;
  localparam int DLO_LSB = 0;

endpackage

// File: rtl/cmd_frame_rcv_uart.sv
// 8N1 UART transceiver. rx_rdy_o holds until clr_rx_rdy_i; tx_done_o is a
// single-cycle pulse once the stop bit has been fully driven.
module cmd_frame_rcv_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data_o,
  output logic       rx_rdy_o,
  input  logic       clr_rx_rdy_i,
  input  logic       trmt_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_done_o
);

  localparam int BW = $clog2(BAUD_DIV);

  logic          rx_s1_q, rx_s2_q, rx_busy_q, rx_rdy_q;
  logic [3:0]    rx_bit_q;
  logic [BW-1:0] rx_baud_q;
  logic [7:0]    rx_shift_q, rx_data_q;

  // First countdown lands mid start bit; every later one lands mid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_rdy_q   <= 1'b0;
      rx_bit_q   <= '0;
      rx_baud_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      if (clr_rx_rdy_i) rx_rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_bit_q  <= '0;
          rx_baud_q <= BW'(BAUD_DIV / 2 - 1);
        end
      end else if (rx_baud_q != '0) begin
        rx_baud_q <= rx_baud_q - BW'(1);
      end else begin
        rx_baud_q <= BW'(BAUD_DIV - 1);
        rx_bit_q  <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;
        end else if (rx_bit_q < 4'd9) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        end else begin
          rx_busy_q <= 1'b0;
          if (rx_s2_q) begin
            rx_data_q <= rx_shift_q;
            rx_rdy_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign rx_data_o = rx_data_q;
  assign rx_rdy_o  = rx_rdy_q;

  logic          tx_q, tx_busy_q, tx_done_q;
  logic [3:0]    tx_bit_q;
  logic [BW-1:0] tx_baud_q;
  logic [8:0]    tx_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_bit_q   <= '0;
      tx_baud_q  <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (trmt_i) begin
          tx_q       <= 1'b0;
          tx_busy_q  <= 1'b1;
          tx_bit_q   <= '0;
          tx_baud_q  <= BW'(BAUD_DIV - 1);
          tx_shift_q <= {1'b1, tx_data_i};
        end
      end else if (tx_baud_q != '0) begin
        tx_baud_q <= tx_baud_q - BW'(1);
      end else begin
        tx_baud_q <= BW'(BAUD_DIV - 1);
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end
    end
  end

  assign tx_o      = tx_q;
  assign tx_done_o = tx_done_q;

endmodule

// File: rtl/cmd_frame_rcv.sv
// Command-link receive endpoint: assembles opcode/data-hi/data-lo bytes into
// cmd with a ready/clear handshake, and returns one response byte on TX.
module cmd_frame_rcv
  import cmd_frame_rcv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int BAUD_DIV    = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic             TX,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             overrun,
  input  logic [7:0]       resp,
  input  logic             send_resp,
  output logic             resp_sent
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [7:0] rx_data;
  logic       rx_rdy, trmt, tx_done;

  cmd_frame_rcv_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (RX),
    .tx_o         (TX),
    .rx_data_o    (rx_data),
    .rx_rdy_o     (rx_rdy),
    .clr_rx_rdy_i (rx_rdy),
    .trmt_i       (trmt),
    .tx_data_i    (resp),
    .tx_done_o    (tx_done)
  );

  rx_state_e        rx_st_q;
  logic [7:0]       hi_byte_q, mid_byte_q;
  logic [CW-1:0]    tmo_cnt_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_rdy_q, overrun_q;
  logic             tmo_hit, frame_done;

  assign tmo_hit    = (rx_st_q != IDLE) && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
  assign frame_done = rx_rdy && (rx_st_q == LOW) && !tmo_hit;

  // A byte landing on the timeout cycle restarts the frame as its opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= IDLE;
      hi_byte_q  <= '0;
      mid_byte_q <= '0;
      tmo_cnt_q  <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (rx_rdy) begin
        tmo_cnt_q <= '0;
        if (rx_st_q == IDLE || tmo_hit) begin
          hi_byte_q <= rx_data;
          rx_st_q   <= MID;
        end else if (rx_st_q == MID) begin
          mid_byte_q <= rx_data;
          rx_st_q    <= LOW;
        end else begin
          cmd_q[OPC_MSB:OPC_LSB] <= hi_byte_q;
          cmd_q[DHI_MSB:DHI_LSB] <= mid_byte_q;
          cmd_q[DLO_MSB:DLO_LSB] <= rx_data;
          rx_st_q                <= IDLE;
        end
      end else if (tmo_hit) begin
        rx_st_q   <= IDLE;
        tmo_cnt_q <= '0;
      end else if (rx_st_q != IDLE) begin
        tmo_cnt_q <= tmo_cnt_q + CW'(1);
      end

      if (frame_done) begin
        cmd_rdy_q <= 1'b1;
        overrun_q <= !clr_cmd_rdy && (overrun_q || cmd_rdy_q);
      end else if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  tx_state_e tx_st_q;
  logic      resp_sent_q;

  assign trmt = (tx_st_q == TIDLE) && send_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q     <= TIDLE;
      resp_sent_q <= 1'b0;
    end else if (tx_st_q == TIDLE) begin
      if (send_resp) begin
        tx_st_q     <= TBUSY;
        resp_sent_q <= 1'b0;
      end
    end else if (tx_done) begin
      tx_st_q     <= TIDLE;
      resp_sent_q <= 1'b1;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign overrun   = overrun_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_frame_rcv.sv
// Bench for cmd_frame_rcv: frame table, hand-built corner sequences and a
// randomized byte stream checked against a frame-level reference model.
module tb_cmd_frame_rcv;

  localparam int TMO = 300;
  localparam int BD  = 8;

  logic        clk = 1'b0, rst_n = 1'b0, RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, overrun, resp_sent;
  logic [23:0] cmd;

  int n_vec = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_frame_rcv #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic        clr;
    logic [23:0] cmd;
    logic        rdy, ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      idle(BD);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    idle(3);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_cmd;
    logic        exp_rdy, exp_ovr;
    logic [7:0]  q[$];
    logic [7:0]  b, rxb;
    logic        bit_s, saw_low;
    int          d, t0, wait_n;

    tbl[0] = '{8'h05, 8'hAB, 8'hCD, 1'b1, 24'h05ABCD, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 8'h02, 8'h03, 1'b1, 24'h010203, 1'b1, 1'b0};
    tbl[2] = '{8'h04, 8'h05, 8'h06, 1'b0, 24'h040506, 1'b1, 1'b1};
    tbl[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 24'hA55AFF, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b1, 24'h000000, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0};

    idle(3);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_resp_sent", resp_sent, 0);
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) pulse_clr();
      send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl%0d_cmd", i), cmd, tbl[i].cmd);
      chk($sformatf("tbl%0d_rdy", i), cmd_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].ovr);
    end
    pulse_clr();
    chk("clr_rdy", cmd_rdy, 0);
    chk("clr_ovr", overrun, 0);
    chk("clr_cmd_hold", cmd, 24'hFFFFFF);

    // Overrun then clear, as a standalone sequence.
    send_frame(8'h01, 8'h02, 8'h03);
    send_frame(8'h04, 8'h05, 8'h06);
    chk("ovr_cmd", cmd, 24'h040506);
    chk("ovr_set", overrun, 1);
    pulse_clr();
    chk("ovr_clr_rdy", cmd_rdy, 0);
    chk("ovr_clr_ovr", overrun, 0);

    // Partial frame abandoned by inter-byte timeout.
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TMO + 10);
    chk("tmo_cmd_hold", cmd, 24'h040506);
    chk("tmo_rdy_hold", cmd_rdy, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(3);
    chk("tmo_no_stale", cmd_rdy, 0);
    send_byte(8'h55);
    idle(3);
    chk("tmo_cmd", cmd, 24'h334455);
    chk("tmo_rdy", cmd_rdy, 1);

    // Measure third-byte start to cmd_rdy, then clear on exactly that cycle.
    pulse_clr();
    d = 0;
    send_byte(8'h61);
    send_byte(8'h62);
    t0 = cyc;
    fork
      send_byte(8'h63);
      begin
        for (int k = 0; k < 12 * BD; k++) begin
          idle(1);
          if (cmd_rdy && d == 0) d = cyc - t0;
        end
      end
    join
    chk("calib_seen", d != 0, 1);
    chk("calib_cmd", cmd, 24'h616263);
    if (d > 1) begin
      chk("same_pre_rdy", cmd_rdy, 1);
      send_byte(8'h71);
      send_byte(8'h72);
      fork
        send_byte(8'h73);
        begin
          repeat (d - 1) @(posedge clk);
          #1 clr_cmd_rdy = 1'b1;
          idle(1);
          clr_cmd_rdy = 1'b0;
        end
      join
      idle(2);
      chk("same_cmd", cmd, 24'h717273);
      chk("same_rdy", cmd_rdy, 1);
      chk("same_ovr", overrun, 0);
    end

    // Response byte on TX; resp changes and a second request during send.
    resp = 8'hA5;
    send_resp = 1'b1;
    idle(1);
    send_resp = 1'b0;
    resp = 8'h3C;
    chk("tx_resp_sent_clr", resp_sent, 0);
    wait_n = 0;
    while (TX !== 1'b0 && wait_n < 4 * BD) begin
      idle(1);
      wait_n++;
    end
    chk("tx_start_seen", wait_n < 4 * BD, 1);
    idle(BD / 2);
    chk("tx_start_bit", TX, 0);
    rxb = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        resp = 8'h96;
        send_resp = 1'b1;
        idle(1);
        send_resp = 1'b0;
        idle(BD - 1);
      end else begin
        idle(BD);
      end
      bit_s = TX;
      rxb[i] = bit_s;
    end
    idle(BD);
    chk("tx_stop_bit", TX, 1);
    chk("tx_byte", rxb, 8'hA5);
    wait_n = 0;
    while (resp_sent !== 1'b1 && wait_n < 4 * BD) begin
      idle(1);
      wait_n++;
    end
    chk("tx_resp_sent", resp_sent, 1);
    saw_low = 1'b0;
    for (int k = 0; k < 12 * BD; k++) begin
      idle(1);
      if (TX !== 1'b1) saw_low = 1'b1;
    end
    chk("tx_no_second", saw_low, 0);

    // Reset in the middle of a frame.
    send_byte(8'h81);
    send_byte(8'h82);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    chk("mrst_rdy", cmd_rdy, 0);
    chk("mrst_cmd", cmd, 0);
    chk("mrst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(3);
    send_frame(8'h0A, 8'h0B, 8'h0C);
    chk("mrst_new_cmd", cmd, 24'h0A0B0C);
    chk("mrst_new_rdy", cmd_rdy, 1);

    // Reset mid-transmit: TX returns high without waiting for a clock.
    resp = 8'h00;
    send_resp = 1'b1;
    idle(1);
    send_resp = 1'b0;
    idle(3 * BD);
    chk("txrst_low", TX, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("txrst_async_high", TX, 1);
    chk("txrst_resp_sent", resp_sent, 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Random byte stream: frames of three, long gaps drop partials.
    exp_cmd = '0;
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
    q.delete();
    for (int n = 0; n < 90; n++) begin
      if ($urandom % 3 == 0) begin
        pulse_clr();
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
      end
      if ($urandom % 5 == 0) begin
        idle(TMO + 20 + int'($urandom % 50));
        q.delete();
      end else begin
        idle(int'($urandom % 40));
      end
      b = 8'($urandom);
      send_byte(b);
      q.push_back(b);
      if (q.size() == 3) begin
        exp_ovr = exp_ovr | exp_rdy;
        exp_rdy = 1'b1;
        exp_cmd = {q[0], q[1], q[2]};
        q.delete();
      end
      idle(3);
      chk($sformatf("rnd%0d_cmd", n), cmd, exp_cmd);
      chk($sformatf("rnd%0d_rdy", n), cmd_rdy, exp_rdy);
      chk($sformatf("rnd%0d_ovr", n), overrun, exp_ovr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
